// File: rtl/piso_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : piso_tx_if
// Description : Word-load handshake and serial output bundle for piso_tx.
// Revision    : 1.0 - initial release
// ============================================================================
interface piso_tx_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] din;
    logic             ready;
    logic             dout;
    logic             dvalid;
    logic             last;

    modport master (
        output load,
        output din,
        input  ready,
        input  dout,
        input  dvalid,
        input  last
    );

    modport slave (
        input  load,
        input  din,
        output ready,
        output dout,
        output dvalid,
        output last
    );
endinterface
`default_nettype wire

// File: rtl/piso_tx.sv
`default_nettype none
// ============================================================================
// Module      : piso_tx
// Description : Parallel-in serial-out transmitter, MSB first, with a
//               ready/load handshake that allows gapless back-to-back words.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_tx #(
    parameter int WIDTH = 4
) (
    input wire       clk,
    input wire       rst,
    piso_tx_if.slave bus
);
    localparam int              c_cnt_w    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_pen_cnt  = c_cnt_w'(WIDTH - 2);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_shift = 1'b1;

    logic [0:0]         r_state;
    logic [WIDTH-1:0]   r_sreg;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_ready;
    logic               r_dvalid;
    logic               r_last;

    // Flags are computed one edge ahead so every output comes straight
    // from a flop; sreg is cleared in IDLE, so its MSB doubles as DOUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_sreg   <= '0;
            r_cnt    <= '0;
            r_ready  <= 1'b1;
            r_dvalid <= 1'b0;
            r_last   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.load) begin
                        r_state  <= c_st_shift;
                        r_sreg   <= bus.din;
                        r_cnt    <= '0;
                        r_ready  <= 1'b0;
                        r_dvalid <= 1'b1;
                        r_last   <= 1'b0;
                    end
                end
                c_st_shift: begin
                    if (r_cnt != c_last_cnt) begin
                        r_sreg  <= r_sreg << 1;
                        r_cnt   <= r_cnt + 1'b1;
                        r_last  <= (r_cnt == c_pen_cnt);
                        r_ready <= (r_cnt == c_pen_cnt);
                    end else if (bus.load) begin
                        r_sreg  <= bus.din;
                        r_cnt   <= '0;
                        r_last  <= 1'b0;
                        r_ready <= 1'b0;
                    end else begin
                        r_state  <= c_st_idle;
                        r_sreg   <= '0;
                        r_cnt    <= '0;
                        r_ready  <= 1'b1;
                        r_dvalid <= 1'b0;
                        r_last   <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= c_st_idle;
                    r_sreg   <= '0;
                    r_cnt    <= '0;
                    r_ready  <= 1'b1;
                    r_dvalid <= 1'b0;
                    r_last   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready  = r_ready;
    assign bus.dout   = r_sreg[WIDTH-1];
    assign bus.dvalid = r_dvalid;
    assign bus.last   = r_last;

endmodule
`default_nettype wire

// File: tb/tb_piso_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_tx
// Description : Directed self-checking bench for piso_tx at WIDTH 4 and 8,
//               with a sipo receiver model looped back from DOUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_tx;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    piso_tx_if #(.WIDTH(4)) bus4 ();
    piso_tx_if #(.WIDTH(8)) bus8 ();

    piso_tx #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
    piso_tx #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));

    logic [3:0] sipo4;
    logic [7:0] sipo8;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receiver side of the link: shifts in each valid bit, first bit ends up on top.
    always @(posedge clk) begin
        if (rst) begin
            sipo4 <= '0;
            sipo8 <= '0;
        end else begin
            if (bus4.dvalid) sipo4 <= {sipo4[2:0], bus4.dout};
            if (bus8.dvalid) sipo8 <= {sipo8[6:0], bus8.dout};
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if ({bus4.ready, bus4.dvalid, bus4.last, bus4.dout} !== 4'b1000) begin
            bad++;
            $display("FAIL reset4 got=%b want=1000", {bus4.ready, bus4.dvalid, bus4.last, bus4.dout});
        end
        total++;
        if ({bus8.ready, bus8.dvalid, bus8.last, bus8.dout} !== 4'b1000) begin
            bad++;
            $display("FAIL reset8 got=%b want=1000", {bus8.ready, bus8.dvalid, bus8.last, bus8.dout});
        end
    endtask

    task automatic test_single;
        logic [3:0] stream;
        logic [3:0] rdy_l;
        stream = 4'b1011;
        rdy_l  = 4'b0001;
        bus4.load = 1'b1;
        bus4.din  = 4'b1011;
        tick();
        bus4.load = 1'b0;
        bus4.din  = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({bus4.ready, bus4.dvalid, bus4.last, bus4.dout} !== {rdy_l[3-k], 1'b1, rdy_l[3-k], stream[3-k]}) begin
                bad++;
                $display("FAIL single k=%0d got=%b want=%b", k,
                         {bus4.ready, bus4.dvalid, bus4.last, bus4.dout},
                         {rdy_l[3-k], 1'b1, rdy_l[3-k], stream[3-k]});
            end
            tick();
        end
        total++;
        if (sipo4 !== 4'b1011) begin
            bad++;
            $display("FAIL single_loopback got=%b want=1011", sipo4);
        end
        total++;
        if ({bus4.ready, bus4.dvalid, bus4.last, bus4.dout} !== 4'b1000) begin
            bad++;
            $display("FAIL single_idle got=%b want=1000", {bus4.ready, bus4.dvalid, bus4.last, bus4.dout});
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] stream;
        logic [7:0] lastpat;
        stream  = 8'b1100_0110;
        lastpat = 8'b0001_0001;
        bus4.load = 1'b1;
        bus4.din  = 4'b1100;
        tick();
        bus4.din  = 4'b0110;
        for (int k = 0; k < 8; k++) begin
            if (k == 7) bus4.load = 1'b0;
            total++;
            if ({bus4.ready, bus4.dvalid, bus4.last, bus4.dout} !== {lastpat[7-k], 1'b1, lastpat[7-k], stream[7-k]}) begin
                bad++;
                $display("FAIL b2b k=%0d got=%b want=%b", k,
                         {bus4.ready, bus4.dvalid, bus4.last, bus4.dout},
                         {lastpat[7-k], 1'b1, lastpat[7-k], stream[7-k]});
            end
            tick();
        end
        total++;
        if (sipo4 !== 4'b0110) begin
            bad++;
            $display("FAIL b2b_loopback got=%b want=0110", sipo4);
        end
        total++;
        if ({bus4.ready, bus4.dvalid, bus4.last, bus4.dout} !== 4'b1000) begin
            bad++;
            $display("FAIL b2b_idle got=%b want=1000", {bus4.ready, bus4.dvalid, bus4.last, bus4.dout});
        end
    endtask

    task automatic test_load_busy;
        logic [3:0] stream;
        stream = 4'b1001;
        bus4.load = 1'b1;
        bus4.din  = 4'b1001;
        tick();
        bus4.load = 1'b0;
        bus4.din  = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({bus4.dvalid, bus4.last, bus4.dout} !== {1'b1, (k == 3), stream[3-k]}) begin
                bad++;
                $display("FAIL busy k=%0d got=%b want=%b", k,
                         {bus4.dvalid, bus4.last, bus4.dout}, {1'b1, (k == 3), stream[3-k]});
            end
            if (k == 1) begin
                bus4.load = 1'b1;
                bus4.din  = 4'b1111;
            end else begin
                bus4.load = 1'b0;
            end
            tick();
        end
        total++;
        if ({bus4.ready, bus4.dvalid, bus4.last, bus4.dout} !== 4'b1000) begin
            bad++;
            $display("FAIL busy_idle got=%b want=1000", {bus4.ready, bus4.dvalid, bus4.last, bus4.dout});
        end
    endtask

    task automatic test_reset_mid;
        logic [3:0] stream;
        bus4.load = 1'b1;
        bus4.din  = 4'b1110;
        tick();
        bus4.load = 1'b0;
        tick();
        total++;
        if ({bus4.dvalid, bus4.dout} !== 2'b11) begin
            bad++;
            $display("FAIL midrst_pre got=%b want=11", {bus4.dvalid, bus4.dout});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({bus4.ready, bus4.dvalid, bus4.last, bus4.dout} !== 4'b1000) begin
            bad++;
            $display("FAIL midrst_post got=%b want=1000", {bus4.ready, bus4.dvalid, bus4.last, bus4.dout});
        end
        stream = 4'b0101;
        bus4.load = 1'b1;
        bus4.din  = 4'b0101;
        tick();
        bus4.load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({bus4.dvalid, bus4.last, bus4.dout} !== {1'b1, (k == 3), stream[3-k]}) begin
                bad++;
                $display("FAIL midrst_word k=%0d got=%b want=%b", k,
                         {bus4.dvalid, bus4.last, bus4.dout}, {1'b1, (k == 3), stream[3-k]});
            end
            tick();
        end
        total++;
        if (sipo4 !== 4'b0101) begin
            bad++;
            $display("FAIL midrst_loopback got=%b want=0101", sipo4);
        end
    endtask

    task automatic test_reset_load;
        rst       = 1'b1;
        bus4.load = 1'b1;
        bus4.din  = 4'b1111;
        tick();
        rst       = 1'b0;
        bus4.load = 1'b0;
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({bus4.ready, bus4.dvalid, bus4.last, bus4.dout} !== 4'b1000) begin
                bad++;
                $display("FAIL rstload k=%0d got=%b want=1000", k,
                         {bus4.ready, bus4.dvalid, bus4.last, bus4.dout});
            end
            tick();
        end
    endtask

    task automatic test_width8;
        logic [7:0] stream;
        stream = 8'b1010_0101;
        bus8.load = 1'b1;
        bus8.din  = 8'hA5;
        tick();
        bus8.load = 1'b0;
        bus8.din  = 8'h00;
        for (int k = 0; k < 8; k++) begin
            total++;
            if ({bus8.ready, bus8.dvalid, bus8.last, bus8.dout} !== {(k == 7), 1'b1, (k == 7), stream[7-k]}) begin
                bad++;
                $display("FAIL w8 k=%0d got=%b want=%b", k,
                         {bus8.ready, bus8.dvalid, bus8.last, bus8.dout},
                         {(k == 7), 1'b1, (k == 7), stream[7-k]});
            end
            tick();
        end
        total++;
        if (sipo8 !== 8'hA5) begin
            bad++;
            $display("FAIL w8_loopback got=%h want=a5", sipo8);
        end
        total++;
        if ({bus8.ready, bus8.dvalid, bus8.last, bus8.dout} !== 4'b1000) begin
            bad++;
            $display("FAIL w8_idle got=%b want=1000", {bus8.ready, bus8.dvalid, bus8.last, bus8.dout});
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        bus4.load = 1'b0;
        bus4.din  = '0;
        bus8.load = 1'b0;
        bus8.din  = '0;
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_load_busy();
        test_reset_mid();
        test_reset_load();
        test_width8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/piso_tx.md
# piso_tx

Parallel-in, serial-out transmitter that converts a WIDTH-bit word into a bit stream, one bit per CLK, MSB first. It is the transmit end of the shift-register link feeding the team's `sipo` receiver: a word loaded here reappears intact on the receiver's parallel output WIDTH cycles after the first bit. A ready/load handshake accepts words back-to-back, so a continuous stream has no idle gaps.

## Interface
- WIDTH, 4, word length in bits; legal range 2..32.
- CLK  input  1  rising-edge clock; all state changes on this edge.
- RST  input  1  synchronous, active-high reset, sampled on the rising edge of CLK.
- LOAD  input  1  word-valid strobe; accepted only on an edge where READY=1.
- DIN  input  WIDTH  parallel word; sampled on the same edge as an accepted LOAD.
- READY  output  1  transmitter can accept a word on this edge.
- DOUT  output  1  serial data bit, MSB of the loaded word first.
- DVALID  output  1  DOUT carries a valid data bit this cycle.
- LAST  output  1  current DOUT bit is the final (LSB) bit of the word.

## Operation
- State: 2-state FSM (IDLE, SHIFT), WIDTH-bit shift register `sreg`, bit counter `cnt` of width clog2(WIDTH).
- Reset: next edge with RST=1 forces IDLE, sreg=0, cnt=0. Outputs after reset: READY=1, DOUT=0, DVALID=0, LAST=0. RST takes priority over LOAD.
- IDLE: READY=1, DVALID=0, LAST=0, DOUT=0.
  - LOAD=1: sreg<=DIN, cnt<=0, go to SHIFT.
  - LOAD=0: stay in IDLE.
- SHIFT: DVALID=1, DOUT=sreg[WIDTH-1], LAST=(cnt==WIDTH-1), READY=LAST.
  - cnt<WIDTH-1: sreg<=sreg<<1 (zero fill), cnt<=cnt+1. LOAD is ignored: no capture, no error, DIN is don't-care.
  - cnt==WIDTH-1 and LOAD=1: sreg<=DIN, cnt<=0, stay in SHIFT. This is a back-to-back word with no gap cycle.
  - cnt==WIDTH-1 and LOAD=0: go to IDLE, sreg<=0, cnt<=0.
- Outputs are decoded only from registered state (Moore style). No combinational path runs from LOAD or DIN to any output.
- Bit order: the k-th transmitted bit (k=0..WIDTH-1) is DIN[WIDTH-1-k]. The sipo receiver places the first received bit in its highest output bit after WIDTH shifts, so the word arrives unpermuted.
- cnt never exceeds WIDTH-1. The counter has no wrap beyond the word boundary.

## Timing
- Handshake: a transfer occurs on a rising edge with READY=1 and LOAD=1. READY is high throughout IDLE and during the LAST cycle of SHIFT.
- Latency: LOAD accepted on edge E. The MSB is on DOUT during the cycle after E. The LSB (LAST=1) is on DOUT during cycle E+WIDTH.
- Throughput: with LOAD held high, DVALID stays high continuously and one word completes every WIDTH cycles.
- Idle return: if LOAD=0 during the LAST cycle, the next cycle shows DVALID=0 and DOUT=0.
- Reset mid-word: the remaining bits are dropped. The cycle after the reset edge shows the reset output values. A LOAD presented on that reset edge is not captured.
- Receiver pairing: drive sipo DIN from DOUT on the same CLK. The sipo parallel output equals the loaded word immediately after the edge that ends the LAST cycle.

## Test plan
- Single word, WIDTH=4, LOAD with DIN=4'b1011 at edge E -> DOUT=1,0,1,1 in cycles E+1..E+4; DVALID=1 for those 4 cycles; LAST=1 only in E+4; READY=0 in E+1..E+3; the looped-back sipo output reads 4'b1011 after E+4.
- Back-to-back: LOAD held high with 4'b1100 then 4'b0110 -> 8 contiguous DVALID cycles, DOUT=1,1,0,0,0,1,1,0, LAST in cycles 4 and 8, no gap cycle.
- LOAD while busy: word 4'b1001, then LOAD=1 with DIN=4'b1111 in cycle E+2 -> ignored; stream remains 1,0,0,1; then return to IDLE.
- Reset mid-word: RST=1 during cycle E+2 of word 4'b1110 -> after the reset edge READY=1, DVALID=0, DOUT=0, LAST=0; a following LOAD of 4'b0101 transmits 0,1,0,1 correctly.
- Reset plus LOAD on the same edge: RST=1 and LOAD=1 with DIN=4'b1111 -> no transmission starts; DVALID stays 0.
- WIDTH=8: DIN=8'hA5 -> DOUT=1,0,1,0,0,1,0,1; LAST only on the 8th bit; an 8-bit sipo loopback reads 8'hA5.
